// File: rtl/uart_cmd_parser_if.sv
// Byte-stream side (rx_done/rxdata) and decoded-command side of the UART frame parser.
interface uart_cmd_parser_if;
  logic        rx_done;
  logic [7:0]  rxdata;
  logic [7:0]  cmd;
  logic [31:0] param;
  logic        cmd_valid;
  logic        sum_err;
  logic        tmo_err;
  logic        busy;

  modport master (output rx_done, rxdata,
                  input  cmd, param, cmd_valid, sum_err, tmo_err, busy);
  modport slave  (input  rx_done, rxdata,
                  output cmd, param, cmd_valid, sum_err, tmo_err, busy);
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses HDR,CMD,D3..D0,SUM frames from a UART byte stream with an inter-byte timeout.
module uart_cmd_parser #(
  parameter logic [7:0]  HDR = 8'hA5,
  parameter logic [15:0] TMO = 16'd50000
) (
  input logic             clkb,
  input logic             rst_n,
  uart_cmd_parser_if.slave bus
);
  typedef enum logic [1:0] {S_HDR, S_CMD, S_DATA, S_SUM} state_t;

  localparam logic [15:0] TMO_LAST = TMO - 16'd1;

  state_t      state, state_nx;
  logic [7:0]  pend_cmd, sum;
  logic [31:0] pend_par;
  logic [1:0]  idx;
  logic [15:0] cnt;
  logic        fire_ok, fire_sum, fire_tmo;
  logic [7:0]  cmd_q;
  logic [31:0] param_q;
  logic        valid_q, sum_err_q, tmo_err_q;

  assign bus.cmd       = cmd_q;
  assign bus.param     = param_q;
  assign bus.cmd_valid = valid_q;
  assign bus.sum_err   = sum_err_q;
  assign bus.tmo_err   = tmo_err_q;
  assign bus.busy      = (state != S_HDR);

  always_ff @(posedge clkb) begin
    if (!rst_n) state <= S_HDR;
    else        state <= state_nx;
  end

  // A byte on the timeout cycle takes priority, so the timeout branch only runs without rx_done.
  always_comb begin
    state_nx = state;
    fire_ok  = 1'b0;
    fire_sum = 1'b0;
    fire_tmo = 1'b0;
    if (bus.rx_done) begin
      case (state)
        S_HDR:  if (bus.rxdata == HDR) state_nx = S_CMD;
        S_CMD:  state_nx = S_DATA;
        S_DATA: if (idx == 2'd3) state_nx = S_SUM;
        S_SUM: begin
          state_nx = S_HDR;
          if (bus.rxdata == sum) fire_ok  = 1'b1;
          else                   fire_sum = 1'b1;
        end
        default: state_nx = S_HDR;
      endcase
    end else if (state != S_HDR && cnt == TMO_LAST) begin
      state_nx = S_HDR;
      fire_tmo = 1'b1;
    end
  end

  always_ff @(posedge clkb) begin
    if (!rst_n) begin
      pend_cmd  <= '0;
      pend_par  <= '0;
      sum       <= '0;
      idx       <= '0;
      cnt       <= '0;
      cmd_q     <= '0;
      param_q   <= '0;
      valid_q   <= 1'b0;
      sum_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      valid_q   <= fire_ok;
      sum_err_q <= fire_sum;
      tmo_err_q <= fire_tmo;
      if (fire_ok) begin
        cmd_q   <= pend_cmd;
        param_q <= pend_par;
      end
      if (bus.rx_done || state == S_HDR || fire_tmo) cnt <= '0;
      else                                           cnt <= cnt + 16'd1;
      if (fire_tmo) begin
        pend_cmd <= '0;
        pend_par <= '0;
        sum      <= '0;
        idx      <= '0;
      end else if (bus.rx_done) begin
        case (state)
          S_CMD: begin
            pend_cmd <= bus.rxdata;
            sum      <= bus.rxdata;
            idx      <= '0;
          end
          S_DATA: begin
            pend_par <= {pend_par[23:0], bus.rxdata};
            sum      <= sum + bus.rxdata;
            idx      <= idx + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed and randomized frames against a byte-queue model of the frame protocol.
module tb_uart_cmd_parser;
  localparam logic [7:0]  HDR = 8'hA5;
  localparam logic [15:0] TMO = 16'd100;

  logic clkb = 1'b0;
  logic rst_n = 1'b0;
  always #5 clkb = ~clkb;

  uart_cmd_parser_if bus ();
  uart_cmd_parser #(.HDR(HDR), .TMO(TMO)) dut (.clkb(clkb), .rst_n(rst_n), .bus(bus));

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Model: bytes of the frame collected so far, and idle cycles since the last byte.
  logic [7:0]  fb[$];
  int          idle;
  logic [7:0]  m_cmd;
  logic [31:0] m_param;
  logic        m_valid, m_sum, m_tmo, m_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step(input logic rd, input logic [7:0] b, input logic rst);
    logic [7:0] s;
    m_valid = 1'b0; m_sum = 1'b0; m_tmo = 1'b0;
    if (!rst) begin
      fb.delete(); idle = 0;
      m_cmd = '0; m_param = '0;
    end else if (rd) begin
      idle = 0;
      if (fb.size() == 0) begin
        if (b == HDR) fb.push_back(b);
      end else begin
        fb.push_back(b);
        if (fb.size() == 7) begin
          s = 8'((int'(fb[1]) + int'(fb[2]) + int'(fb[3]) + int'(fb[4]) + int'(fb[5])) % 256);
          if (b == s) begin
            m_valid = 1'b1;
            m_cmd   = fb[1];
            m_param = {fb[2], fb[3], fb[4], fb[5]};
          end else m_sum = 1'b1;
          fb.delete();
        end
      end
    end else if (fb.size() > 0) begin
      idle++;
      if (idle == int'(TMO)) begin
        m_tmo = 1'b1;
        fb.delete();
        idle = 0;
      end
    end
    m_busy = (fb.size() > 0);
  endtask

  task automatic cycle(input logic rd, input logic [7:0] b);
    bus.rx_done = rd;
    bus.rxdata  = b;
    @(posedge clkb); #1;
    model_step(rd, b, rst_n);
    chk("cmd",       32'(bus.cmd),       32'(m_cmd));
    chk("param",     bus.param,          m_param);
    chk("cmd_valid", 32'(bus.cmd_valid), 32'(m_valid));
    chk("sum_err",   32'(bus.sum_err),   32'(m_sum));
    chk("tmo_err",   32'(bus.tmo_err),   32'(m_tmo));
    chk("busy",      32'(bus.busy),      32'(m_busy));
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    idle_n(gap);
    cycle(1'b1, b);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] p, input logic bad);
    logic [7:0] s;
    s = c + p[31:24] + p[23:16] + p[15:8] + p[7:0];
    if (bad) s = s ^ 8'(1 + $urandom_range(0, 254));
    send(HDR, $urandom_range(0, 3));
    send(c, $urandom_range(0, 5));
    for (int i = 3; i >= 0; i--) send(p[i*8 +: 8], $urandom_range(0, 5));
    send(s, $urandom_range(0, 5));
  endtask

  initial begin
    logic [7:0] seq30[7];
    logic [7:0] seq31[7];
    logic [7:0] seq32[9];
    seq30 = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h15};
    seq31 = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    seq32 = '{8'h33, 8'hFF, 8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
    idle = 0;
    bus.rx_done = 1'b0;
    bus.rxdata  = 8'h00;

    // reset, with bytes offered while held in reset
    rst_n = 1'b0;
    cycle(1'b1, HDR);
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h01);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_cmd",  32'(bus.cmd),  32'd0);

    // basic good frame
    for (int i = 0; i < 7; i++) send(seq30[i], 2);
    chk("r30_valid", 32'(bus.cmd_valid), 32'd1);
    chk("r30_cmd",   32'(bus.cmd),       32'h01);
    chk("r30_param", bus.param,          32'h12345678);
    chk("r30_busy",  32'(bus.busy),      32'd0);
    cycle(1'b0, 8'h00);
    chk("r30_pulse_len", 32'(bus.cmd_valid), 32'd0);

    // bad checksum
    for (int i = 0; i < 7; i++) send(seq31[i], 1);
    chk("r31_sum_err", 32'(bus.sum_err),   32'd1);
    chk("r31_novalid", 32'(bus.cmd_valid), 32'd0);
    chk("r31_param",   bus.param,          32'h12345678);
    idle_n(2);

    // leading junk
    for (int i = 0; i < 9; i++) send(seq32[i], 1);
    chk("r32_valid", 32'(bus.cmd_valid), 32'd1);
    chk("r32_cmd",   32'(bus.cmd),       32'h03);
    chk("r32_param", bus.param,          32'h0);

    // timeout after two bytes, then a good frame
    send(HDR, 1);
    send(8'h04, 1);
    idle_n(int'(TMO) - 1);
    chk("r33_pre_tmo", 32'(bus.tmo_err), 32'd0);
    idle_n(1);
    chk("r33_tmo",  32'(bus.tmo_err), 32'd1);
    chk("r33_busy", 32'(bus.busy),    32'd0);
    send_frame(8'h44, 32'hDEADBEEF, 1'b0);
    chk("r33_after_cmd",   32'(bus.cmd), 32'h44);
    chk("r33_after_param", bus.param,    32'hDEADBEEF);

    // byte exactly on the timeout cycle wins; then reset mid-frame
    send(HDR, 0);
    send(8'h05, 0);
    send(8'h11, int'(TMO) - 1);
    chk("r34_no_tmo",  32'(bus.tmo_err), 32'd0);
    chk("r34_busy",    32'(bus.busy),    32'd1);
    rst_n = 1'b0;
    cycle(1'b0, 8'h00);
    rst_n = 1'b1;
    chk("r34_rst_cmd",  32'(bus.cmd),  32'd0);
    chk("r34_rst_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 4; i++) send(8'h22, 0);
    chk("r34_need_hdr", 32'(bus.busy), 32'd0);
    idle_n(3);

    // back-to-back frames, second header right after cmd_valid; header bytes as payload
    for (int i = 0; i < 7; i++) send(seq30[i], 0);
    chk("r35_first", 32'(bus.cmd_valid), 32'd1);
    send(HDR, 0);
    chk("r35_accept_hdr", 32'(bus.busy), 32'd1);
    send(HDR, 0);
    for (int i = 0; i < 4; i++) send(HDR, 0);
    send(8'(5 * 8'hA5), 0);
    chk("r35_second_cmd",   32'(bus.cmd), 32'hA5);
    chk("r35_second_param", bus.param,    32'hA5A5A5A5);

    // randomized frames, junk, corrupted sums and occasional timeouts
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0) send(8'($urandom), $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        send(HDR, 0);
        send(8'($urandom), 0);
        idle_n(int'(TMO) + $urandom_range(0, 3));
      end
      send_frame(8'($urandom), $urandom, ($urandom_range(0, 3) == 0));
    end
    idle_n(5);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter HDR, default 8'hA5, frame header byte.
REQ-002 SHALL have parameter TMO, default 16'd50000, inter-byte timeout in clkb cycles.
REQ-003 SHALL have port clkb  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx_done  input  1  one-cycle pulse from the upstream UART receiver; the byte is valid this cycle.
REQ-006 SHALL have port rxdata  input  8  received byte, sampled only when rx_done=1.
REQ-007 SHALL have port cmd  output  8  opcode of the last good frame.
REQ-008 SHALL have port param  output  32  parameter of the last good frame, big-endian.
REQ-009 SHALL have port cmd_valid  output  1  one-cycle pulse when cmd/param are updated.
REQ-010 SHALL have port sum_err  output  1  one-cycle pulse on a checksum mismatch.
REQ-011 SHALL have port tmo_err  output  1  one-cycle pulse on an inter-byte timeout.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress (state not S_HDR).

Function
REQ-013 Frame format SHALL be 7 bytes: HDR, CMD, D3, D2, D1, D0, SUM; SUM = (CMD+D3+D2+D1+D0) mod 256.
REQ-014 States SHALL be S_HDR, S_CMD, S_DATA, S_SUM; the state advances only on cycles with rx_done=1.
REQ-015 In S_HDR, a byte equal to HDR SHALL go to S_CMD; any other byte is discarded and the state stays S_HDR.
REQ-016 In S_CMD, the byte SHALL be stored as the pending opcode, the running sum is loaded with it, the byte index is cleared, and the state goes to S_DATA.
REQ-017 In S_DATA, each byte SHALL shift into a 32-bit pending register MSB-first and be added to the sum mod 256; after the 4th byte (index 3) the state goes to S_SUM.
REQ-018 In S_SUM, when the byte equals the running sum, the cycle after rx_done SHALL load cmd and param from the pending registers and pulse cmd_valid for 1 cycle.
REQ-019 In S_SUM, when the byte differs from the running sum, sum_err SHALL pulse for 1 cycle and cmd/param hold their values.
REQ-020 After an S_SUM byte, the state SHALL return to S_HDR regardless of the result.
REQ-021 A header value inside CMD/DATA/SUM positions SHALL be treated as payload, not as a resync.
REQ-022 Timeout counter SHALL be 16 bits, cleared on every rx_done and in S_HDR, and increment each cycle in other states.
REQ-023 When the counter reaches TMO-1 without rx_done, the state SHALL go to S_HDR, tmo_err pulses 1 cycle, and the pending data is discarded.
REQ-024 When rx_done coincides with the timeout cycle, the byte SHALL win: it is processed normally, the counter clears, and there is no tmo_err.
REQ-025 cmd_valid, sum_err and tmo_err SHALL be mutually exclusive and never high for 2 consecutive cycles from one event.
REQ-026 A new header arriving the cycle after cmd_valid SHALL be accepted (zero dead time).
REQ-027 rxdata SHALL be ignored when rx_done=0.

Reset
REQ-028 While rst_n=0 at a clkb edge: state=S_HDR, cmd=0, param=0, cmd_valid=0, sum_err=0, tmo_err=0, busy=0, counter=0, sum=0, index=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no error pulse; the next frame SHALL need a fresh HDR.

Verification
REQ-030 Feed A5,01,12,34,56,78,15 -> cmd_valid pulse 1 cycle after the last rx_done, cmd=01, param=32'h12345678, busy back to 0.
REQ-031 Feed A5,02,00,00,00,01,00 -> sum_err pulse, cmd/param unchanged, no cmd_valid.
REQ-032 Feed 33,FF,A5,03,00,00,00,00,03 -> leading junk ignored, cmd_valid with cmd=03, param=0.
REQ-033 Set TMO=100; feed A5,04 then idle 100 cycles -> tmo_err pulse at cycle 100, busy=0; a following full good frame decodes correctly.
REQ-034 Send rx_done exactly on the TMO-1 cycle -> no tmo_err, frame continues; drop rst_n after the 3rd byte -> no pulses, outputs reset to 0.
REQ-035 Send two back-to-back good frames with the second HDR the cycle after cmd_valid -> two cmd_valid pulses with the correct values.
